// File: rtl/spi_transaction_fsm_if.sv
// Handshake bundle between the SPI input conditioners and the transaction sequencer.
// master drives CS/SCLK-edge/R/W; slave (the sequencer) drives the datapath strobes.
interface spi_transaction_fsm_if;
  logic chipSelect;
  logic sclkPosEdge;
  logic rwBit;
  logic srShiftEnable;
  logic srParallelLoad;
  logic addrLatchEnable;
  logic dmWriteEnable;
  logic misoBufEnable;
  logic busy;

  modport master (
    output chipSelect, sclkPosEdge, rwBit,
    input  srShiftEnable, srParallelLoad, addrLatchEnable,
           dmWriteEnable, misoBufEnable, busy
  );

  modport slave (
    input  chipSelect, sclkPosEdge, rwBit,
    output srShiftEnable, srParallelLoad, addrLatchEnable,
           dmWriteEnable, misoBufEnable, busy
  );
endinterface

// File: rtl/spi_transaction_fsm.sv
// SPI slave transaction sequencer: counts SCLK edges through the address and data
// phases and strobes the shift register, address latch, data memory and MISO buffer.
module spi_transaction_fsm #(
  parameter int width = 8
) (
  input logic                   clk,
  input logic                   reset,
  spi_transaction_fsm_if.slave  bus
);
  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_MEM, DONE
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] bitCnt, bitCntNext;
  logic          readPath, readPathNext;
  logic          counting, edgeAccepted, lastEdge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      readPath <= 1'b0;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      readPath <= readPathNext;
    end
  end

  always_comb begin
    counting     = (state == GET_ADDR) || (state == READ_SEND) || (state == WRITE_RECV);
    // CS high masks the edge so an abort always wins over a same-cycle SCLK pulse
    edgeAccepted = counting && bus.sclkPosEdge && !bus.chipSelect;
    lastEdge     = edgeAccepted && (bitCnt == LAST);
    stateNext    = state;
    bitCntNext   = edgeAccepted ? bitCnt + 1'b1 : bitCnt;

    if (bus.chipSelect) begin
      stateNext  = IDLE;
      bitCntNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          stateNext  = GET_ADDR;
          bitCntNext = '0;
        end
        GET_ADDR:   if (lastEdge) stateNext = GOT_ADDR;
        GOT_ADDR: begin
          bitCntNext = '0;
          stateNext  = bus.rwBit ? READ_LOAD : WRITE_RECV;
        end
        READ_LOAD: begin
          stateNext  = READ_SEND;
          bitCntNext = '0;
        end
        READ_SEND:  if (lastEdge) stateNext = DONE;
        WRITE_RECV: if (lastEdge) stateNext = WRITE_MEM;
        WRITE_MEM:  stateNext = DONE;
        DONE:       stateNext = DONE;
        default: begin
          stateNext  = IDLE;
          bitCntNext = '0;
        end
      endcase
    end

    // remember a read finished so MISO stays driven while the master drains DONE
    readPathNext = (stateNext == DONE) && (readPath || (state == READ_SEND));
  end

  assign bus.srShiftEnable   = edgeAccepted;
  assign bus.addrLatchEnable = (state == GOT_ADDR);
  assign bus.srParallelLoad  = (state == READ_LOAD);
  assign bus.dmWriteEnable   = (state == WRITE_MEM);
  assign bus.misoBufEnable   = (state == READ_SEND) || ((state == DONE) && readPath);
  assign bus.busy            = (state != IDLE);
endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Scoreboard bench: stimulus queues expected strobe events, a negedge monitor pops and checks them.
module tb_spi_transaction_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mosi = 1'b0;
  logic [7:0] sr;
  int checks = 0;
  int failures = 0;

  localparam logic [3:0] SH = 4'b0001, AL = 4'b0010, PL = 4'b0100, DM = 4'b1000;

  typedef struct packed {
    logic [3:0] kind;
    logic       miso;
    logic [7:0] data;
  } ev_t;
  ev_t expQ[$];

  spi_transaction_fsm_if bus();

  spi_transaction_fsm #(.width(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // behavioural shift register so rwBit and latched values come from the bits actually shifted
  always @(posedge clk or posedge reset)
    if (reset) sr <= 8'h00;
    else if (bus.srShiftEnable) sr <= {sr[6:0], mosi};
  assign bus.rwBit = sr[7];

  always @(negedge clk) begin
    logic [3:0] obs;
    ev_t e;
    obs = {bus.dmWriteEnable, bus.srParallelLoad, bus.addrLatchEnable, bus.srShiftEnable};
    if (obs != 4'b0000) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe act=%b exp=none t=%0t", obs, $time);
      end else begin
        e = expQ.pop_front();
        if (obs != e.kind || bus.misoBufEnable != e.miso ||
            (e.kind == AL && sr[6:0] != e.data[6:0]) ||
            (e.kind == DM && sr != e.data)) begin
          failures++;
          $display("FAIL strobe_event kind act=%b exp=%b miso act=%b exp=%b data act=%h exp=%h t=%0t",
                   obs, e.kind, bus.misoBufEnable, e.miso, sr, e.data, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic b);
    mosi = b;
    bus.sclkPosEdge = 1'b1;
    tick(1);
    bus.sclkPosEdge = 1'b0;
    tick(9);
  endtask

  task automatic sendBits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) pulse(v[7-i]);
  endtask

  task automatic expShifts(input int n, input logic miso);
    for (int i = 0; i < n; i++) expQ.push_back('{SH, miso, 8'h00});
  endtask

  task automatic checkIdleOutputs(input string name);
    check(name, {bus.srShiftEnable, bus.srParallelLoad, bus.addrLatchEnable,
                 bus.dmWriteEnable, bus.misoBufEnable, bus.busy}, 0);
  endtask

  task automatic startXfer();
    bus.chipSelect = 1'b0;
    check("busy_before_cs_edge", bus.busy, 1'b0);
    tick(1);
    check("busy_rise", bus.busy, 1'b1);
    tick(1);
  endtask

  task automatic endXfer();
    bus.chipSelect = 1'b1;
    check("busy_hold", bus.busy, 1'b1);
    tick(1);
    check("busy_fall", bus.busy, 1'b0);
  endtask

  task automatic doRead(input logic [6:0] addr);
    expShifts(8, 1'b0);
    expQ.push_back('{AL, 1'b0, {1'b0, addr}});
    expQ.push_back('{PL, 1'b0, 8'h00});
    expShifts(8, 1'b1);
    startXfer();
    sendBits({1'b1, addr}, 8);
    sendBits(8'h00, 8);
    check("read_miso_in_done", bus.misoBufEnable, 1'b1);
    pulse(1'b1);  // ignored in DONE
    check("read_miso_after_extra", bus.misoBufEnable, 1'b1);
    endXfer();
    check("read_miso_idle", bus.misoBufEnable, 1'b0);
  endtask

  task automatic doWrite(input logic [6:0] addr, input logic [7:0] data);
    expShifts(8, 1'b0);
    expQ.push_back('{AL, 1'b0, {1'b0, addr}});
    expShifts(8, 1'b0);
    expQ.push_back('{DM, 1'b0, data});
    startXfer();
    sendBits({1'b0, addr}, 8);
    sendBits(data, 8);
    check("write_miso_in_done", bus.misoBufEnable, 1'b0);
    pulse(1'b0);  // ignored in DONE
    endXfer();
  endtask

  initial begin
    bus.chipSelect = 1'b1;
    bus.sclkPosEdge = 1'b0;
    tick(3);
    checkIdleOutputs("reset_outputs");
    reset = 1'b0;
    tick(2);
    checkIdleOutputs("post_reset_idle");

    // reset in the middle of the address phase
    expShifts(3, 1'b0);
    startXfer();
    sendBits(8'hFF, 3);
    bus.sclkPosEdge = 1'b1;
    reset = 1'b1;
    #1;
    checkIdleOutputs("reset_mid_addr");
    bus.sclkPosEdge = 1'b0;
    bus.chipSelect = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);

    doRead(7'h15);
    tick(3);
    doWrite(7'h2A, 8'hA5);
    tick(3);

    // abort after 5 address edges, then a full read must still count from zero
    expShifts(5, 1'b0);
    startXfer();
    sendBits(8'h80, 5);
    endXfer();
    tick(2);
    doRead(7'h33);
    tick(3);

    // abort during the data phase of a write
    expShifts(8, 1'b0);
    expQ.push_back('{AL, 1'b0, 8'h4C});
    expShifts(7, 1'b0);
    startXfer();
    sendBits(8'h4C, 8);
    sendBits(8'hFF, 7);
    endXfer();
    tick(12);

    // CS rises in the same cycle as the 8th address edge
    expShifts(7, 1'b0);
    startXfer();
    sendBits(8'h81, 7);
    bus.chipSelect = 1'b1;
    bus.sclkPosEdge = 1'b1;
    mosi = 1'b1;
    #1;
    check("shift_masked_by_cs", bus.srShiftEnable, 1'b0);
    tick(1);
    bus.sclkPosEdge = 1'b0;
    check("cs_edge_abort_idle", bus.busy, 1'b0);
    tick(12);

    // back-to-back write then read with CS high for 2 cycles between
    doWrite(7'h01, 8'h3C);
    tick(1);
    doRead(7'h7F);
    tick(5);

    check("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_transaction_fsm.md
# spi_transaction_fsm

Sequencing controller for the SPI slave datapath built around the `shiftRegister` block. It watches chip select and conditioned SCLK edge pulses, counts bits, and decides when the address is complete and whether the transfer is a read or a write. It then drives the shift register's parallel-load and shift-enable, the address latch, the memory write-enable and the MISO tristate buffer. It sits between the input conditioners for CS and SCLK and the shift register, address latch and data memory.

## Interface
- `width`, 8: bits per phase (address+R/W phase and data phase); must match the `shiftRegister` width.
- `clk`  input  1  system clock; all state changes on posedge.
- `reset`  input  1  asynchronous, active-high reset.
- `chipSelect`  input  1  synchronized CS, active low; a transaction is open while 0.
- `sclkPosEdge`  input  1  one-`clk`-cycle pulse per SCLK rising edge, synchronous to `clk`.
- `rwBit`  input  1  R/W flag, wired to shift register `parallelDataOut[width-1]`; 1 = read, 0 = write.
- `srShiftEnable`  output  1  drives shift register `peripheralClkEdge`.
- `srParallelLoad`  output  1  drives shift register `parallelLoad`.
- `addrLatchEnable`  output  1  one-cycle strobe that captures the address from the shift register.
- `dmWriteEnable`  output  1  one-cycle data memory write strobe.
- `misoBufEnable`  output  1  enables the MISO tristate buffer.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_MEM, DONE.
- Bit counter: `$clog2(width)+1` bits. Cleared on entry to GET_ADDR, READ_SEND and WRITE_RECV. Increments on each `sclkPosEdge` accepted in those states.
- IDLE: when `chipSelect`==0, go to GET_ADDR.
- GET_ADDR: count `width` accepted edges. On the edge that makes the count equal `width`, go to GOT_ADDR.
- GOT_ADDR: one cycle. Go to READ_LOAD if `rwBit`==1, otherwise go to WRITE_RECV.
- READ_LOAD: one cycle, then READ_SEND.
- READ_SEND: count `width` accepted edges, then go to DONE.
- WRITE_RECV: count `width` accepted edges, then go to WRITE_MEM.
- WRITE_MEM: one cycle, then DONE.
- DONE: hold until `chipSelect`==1, then go to IDLE.
- Abort: `chipSelect`==1 in any state sends the FSM to IDLE on the next posedge. Abort has priority over a same-cycle `sclkPosEdge`. An aborted transaction never asserts `dmWriteEnable`.
- Outputs are Moore-decoded from the state register, except `srShiftEnable`:
  - `srShiftEnable` = `sclkPosEdge` & `chipSelect`==0 & state ∈ {GET_ADDR, READ_SEND, WRITE_RECV}.
  - `addrLatchEnable` is 1 only in GOT_ADDR.
  - `srParallelLoad` is 1 only in READ_LOAD.
  - `dmWriteEnable` is 1 only in WRITE_MEM.
  - `misoBufEnable` is 1 in READ_SEND and in DONE when DONE was entered from READ_SEND.
- `sclkPosEdge` pulses arriving in GOT_ADDR, READ_LOAD, WRITE_MEM, DONE or IDLE are ignored and not counted.
- Reset: state IDLE, counter 0, all outputs 0 (including the read-path flag behind `misoBufEnable`). Reset mid-transaction aborts it immediately, with no write strobe.

## Timing
- With one `clk` edge per state transition, `addrLatchEnable` is high for exactly one cycle. That cycle is the one after the `clk` edge that sampled the `width`-th address `sclkPosEdge`. At that point `parallelDataOut` holds all `width` received bits.
- `srParallelLoad` is high in the cycle after `addrLatchEnable`. It is a single pulse.
- `dmWriteEnable` is high in the cycle after the `clk` edge that sampled the `width`-th data `sclkPosEdge`. It is a single pulse.
- Consecutive `sclkPosEdge` pulses must be at least 4 `clk` cycles apart. This guarantees the one-cycle states never drop an edge.
- `busy` rises the cycle after CS falls. It falls the cycle after CS rises.

## Test plan
1. Reset assertion and release → all outputs 0 and state IDLE. Assert `reset` mid-GET_ADDR after 3 edges → outputs 0 on the same cycle, no strobes afterwards.
2. Read, `width`=8, address 7'h15 + R/W=1 (8 edges, 10 `clk` apart) → exactly 8 `srShiftEnable` pulses, then `addrLatchEnable` one cycle, `srParallelLoad` the next cycle, `misoBufEnable` high for the next 8 edges and through DONE, `dmWriteEnable` never high.
3. Write, address 7'h2A + R/W=0, data 8'hA5 → 16 shift pulses, one `addrLatchEnable`, one `dmWriteEnable` one cycle after the 16th edge, `misoBufEnable` never high.
4. Abort: raise CS after 5 address edges → IDLE next cycle, no `addrLatchEnable`, and the next transaction counts from 0. Raise CS during WRITE_RECV after 7 data edges → no `dmWriteEnable`.
5. CS rising in the same cycle as the 8th address `sclkPosEdge` → `srShiftEnable` 0 that cycle, IDLE, no `addrLatchEnable`.
6. Back-to-back: a write then a read, with CS high for 2 cycles between them → both complete with correct strobe counts. Extra SCLK pulses in DONE are not counted.
